// File: rtl/twin_reg_arbiter_if.sv
// Client/consumer bundle for the twin register arbiter.
//   master : producers and consumer (drive req/d/q_ack, observe gnt/q)
//   slave  : the arbiter (observes req/d/q_ack, drives gnt/q)
interface twin_reg_arbiter_if #(
    parameter int unsigned DW = 8
);
    logic          req0;
    logic [DW-1:0] d1_0;
    logic [DW-1:0] d2_0;
    logic          req1;
    logic [DW-1:0] d1_1;
    logic [DW-1:0] d2_1;
    logic          q_ack;
    logic          gnt0;
    logic          gnt1;
    logic [DW-1:0] q1;
    logic [DW-1:0] q2;
    logic          q_valid;
    logic          q_owner;

    modport master (
        output req0, d1_0, d2_0, req1, d1_1, d2_1, q_ack,
        input  gnt0, gnt1, q1, q2, q_valid, q_owner
    );

    modport slave (
        input  req0, d1_0, d2_0, req1, d1_1, d2_1, q_ack,
        output gnt0, gnt1, q1, q2, q_valid, q_owner
    );
endinterface

// File: rtl/twin_reg_arbiter.sv
// Round-robin arbiter sharing one twin register pair (q1/q2) between two
// clients. The winner's d1/d2 is captured atomically and held valid until
// the consumer acknowledges it.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of twin_reg_arbiter_if (requests, data, grants,
//          held pair, valid, owner, consumer ack)
module twin_reg_arbiter #(
    parameter int unsigned DW = 8
) (
    input  logic               clk,
    input  logic               rst,
    twin_reg_arbiter_if.slave  bus
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] q1_r;
    logic [DW-1:0] q2_r;
    logic          q_valid_r;
    logic          q_owner_r;
    logic          gnt0_r;
    logic          gnt1_r;
    logic          last_owner;

    logic [DW-1:0] q1_nxt;
    logic [DW-1:0] q2_nxt;
    logic          q_valid_nxt;
    logic          q_owner_nxt;
    logic          gnt0_nxt;
    logic          gnt1_nxt;
    logic          last_owner_nxt;

    logic          any_req_c;
    logic          winner_c;

    // Sole requester wins; on contention the client that did not go last wins.
    assign any_req_c = bus.req0 | bus.req1;
    assign winner_c  = bus.req1 & (~bus.req0 | ~last_owner);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            q1_r       <= '0;
            q2_r       <= '0;
            q_valid_r  <= 1'b0;
            q_owner_r  <= 1'b0;
            gnt0_r     <= 1'b0;
            gnt1_r     <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            q1_r       <= q1_nxt;
            q2_r       <= q2_nxt;
            q_valid_r  <= q_valid_nxt;
            q_owner_r  <= q_owner_nxt;
            gnt0_r     <= gnt0_nxt;
            gnt1_r     <= gnt1_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req_c) state_nxt = HOLD;
            HOLD:    if (bus.q_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; grants default low so each is one cycle wide.
    always_comb begin
        q1_nxt         = q1_r;
        q2_nxt         = q2_r;
        q_valid_nxt    = q_valid_r;
        q_owner_nxt    = q_owner_r;
        gnt0_nxt       = 1'b0;
        gnt1_nxt       = 1'b0;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (any_req_c) begin
                    q1_nxt      = winner_c ? bus.d1_1 : bus.d1_0;
                    q2_nxt      = winner_c ? bus.d2_1 : bus.d2_0;
                    q_owner_nxt = winner_c;
                    q_valid_nxt = 1'b1;
                    gnt0_nxt    = ~winner_c;
                    gnt1_nxt    = winner_c;
                end
            end
            HOLD: begin
                // Pair data is kept after release; only valid drops.
                if (bus.q_ack) begin
                    q_valid_nxt    = 1'b0;
                    last_owner_nxt = q_owner_r;
                end
            end
            default: begin
                q_valid_nxt = 1'b0;
            end
        endcase
    end

    assign bus.q1      = q1_r;
    assign bus.q2      = q2_r;
    assign bus.q_valid = q_valid_r;
    assign bus.q_owner = q_owner_r;
    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;

endmodule

// File: tb/tb_twin_reg_arbiter.sv
// Directed self-checking bench for twin_reg_arbiter.
module tb_twin_reg_arbiter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    twin_reg_arbiter_if #(.DW(8)) bus ();

    twin_reg_arbiter #(.DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs: {q_valid, q_owner, gnt0, gnt1, q1, q2}
    logic [19:0] obs;
    assign obs = {bus.q_valid, bus.q_owner, bus.gnt0, bus.gnt1, bus.q1, bus.q2};

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [19:0] exp;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.q_ack = 1'b0;
        bus.d1_0 = 8'h00; bus.d2_0 = 8'h00; bus.d1_1 = 8'h00; bus.d2_1 = 8'h00;
        rst = 1'b1;
        #3;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [19:0] exp;
        bus.req0 = 1'b1; bus.d1_0 = 8'hA5; bus.d2_0 = 8'h3C;
        step();
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL single_capture: got %h expected %h", obs, exp);
        end
        bus.req0 = 1'b0;
        step();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL single_gnt_width: got %h expected %h", obs, exp);
        end
        bus.q_ack = 1'b1;
        step();
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL single_release: got %h expected %h", obs, exp);
        end
        bus.q_ack = 1'b0;
    endtask

    task automatic test_contention();
        logic [19:0] exp;
        logic [7:0]  e1;
        logic [7:0]  e2;
        logic        own;
        apply_reset();
        bus.d1_0 = 8'h10; bus.d2_0 = 8'h20; bus.d1_1 = 8'h30; bus.d2_1 = 8'h40;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.q_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            own = (k % 2) == 1;
            e1  = own ? 8'h30 : 8'h10;
            e2  = own ? 8'h40 : 8'h20;
            step();
            exp = {1'b1, own, ~own, own, e1, e2};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL contention_grant%0d: got %h expected %h", k, obs, exp);
            end
            step();
            exp = {1'b0, own, 1'b0, 1'b0, e1, e2};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL contention_release%0d: got %h expected %h", k, obs, exp);
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.q_ack = 1'b0;
        step();
    endtask

    task automatic test_hold();
        logic [19:0] exp;
        bus.req1 = 1'b1; bus.d1_1 = 8'h11; bus.d2_1 = 8'h22; bus.q_ack = 1'b0;
        step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL hold_capture: got %h expected %h", obs, exp);
        end
        bus.req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.d1_0 = 8'(i * 7 + 1);
            bus.d2_0 = 8'(i * 13 + 2);
            bus.d1_1 = 8'(8'hF0 ^ i);
            bus.d2_1 = 8'(8'h0F ^ (i << 4));
            step();
            exp = {1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL hold_stable%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_ack_release();
        logic [19:0] exp;
        bus.q_ack = 1'b1;
        step();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 8'h22};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL ack_release: got %h expected %h", obs, exp);
        end
        bus.q_ack = 1'b0;
        bus.d1_0 = 8'h5A; bus.d2_0 = 8'hC3; bus.d1_1 = 8'h77; bus.d2_1 = 8'h88;
        step();
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hC3};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL ack_next_other: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] exp;
        // Release client 0 so last_owner=0, then let client 1 win the next round.
        bus.q_ack = 1'b1;
        step();
        bus.q_ack = 1'b0;
        step();
        exp = {1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 8'h88};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL areset_setup: got %h expected %h", obs, exp);
        end
        #2;
        rst = 1'b1;
        #1;
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL areset_immediate: got %h expected %h", obs, exp);
        end
        #1;
        rst = 1'b0;
        step();
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hC3};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL areset_winner0: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_idle_ack();
        logic [19:0] exp;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.q_ack = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            exp = {1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'hC3};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL idle_ack%0d: got %h expected %h", i, obs, exp);
            end
        end
        bus.q_ack = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_ack_release();
        test_async_reset();
        test_idle_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
